// File: rtl/vga_timing_gen.sv
// Video timing source for vga_driver: pixel/line counters, sync generation and AXI4-Stream pixel fetch.
// Build macro VGA_TEST_PATTERN_EN adds a pattern_sel input that replaces stream data with colour bars.
`timescale 1ns/1ps
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        err_clr,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        pattern_sel,
`endif
    input  logic [23:0] s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tuser,
    output logic        s_tready,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        valid_o,
    output logic [23:0] rgb_o,
    output logic        underflow,
    output logic        sync_err
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare count of headroom so sync-window end constants never wrap when the back porch is 0.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [HW-1:0]   h_cnt;
    logic [HW-1:0]   h_nxt;
    logic [VW-1:0]   v_cnt;
    logic [VW-1:0]   v_nxt;
    logic            resync;
    logic            resync_nxt;

    logic            frame_end;
    logic            active;
    logic            h_sync_win;
    logic            v_sync_win;
    logic            pat;
    logic [23:0]     bar_rgb;

    logic            tready;
    logic            sof_miss;
    logic            underflow_set;
    logic            hsync_nxt;
    logic            vsync_nxt;
    logic            valid_nxt;
    logic [23:0]     rgb_nxt;

    assign frame_end  = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign h_sync_win = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign v_sync_win = (v_cnt >= VS_START) && (v_cnt < VS_END);

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;

    assign pat     = pattern_sel && (state != IDLE);
    assign bar     = 3'((32'(h_cnt) * 32'd8) / 32'(H_ACTIVE));
    assign bar_rgb = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
`else
    assign pat     = 1'b0;
    assign bar_rgb = '0;
`endif

    // Counters: held at the origin while idle, free-running raster otherwise.
    always_comb begin
        h_nxt = '0;
        v_nxt = '0;
        if (state != IDLE) begin
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_nxt = h_cnt + 1'b1;
                v_nxt = v_cnt;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        tready        = 1'b0;
        sof_miss      = 1'b0;
        underflow_set = 1'b0;
        resync_nxt    = 1'b0;
        valid_nxt     = 1'b0;
        rgb_nxt       = '0;
        hsync_nxt     = ~SYNC_POL;
        vsync_nxt     = ~SYNC_POL;

        if (state != IDLE) begin
            if (h_sync_win) hsync_nxt = SYNC_POL;
            if (v_sync_win) vsync_nxt = SYNC_POL;
        end

        case (state)
            IDLE: begin
                if (en) state_nxt = WAIT_SOF;
            end
            WAIT_SOF: begin
                // Drain stale beats but leave the SOF beat waiting for the next frame start.
                tready = s_tvalid && !s_tuser && !pat;
                if (frame_end) begin
                    if (!en)
                        state_nxt = IDLE;
                    else if (s_tvalid && s_tuser)
                        state_nxt = RUN;
                end
            end
            RUN: begin
                if (!pat) begin
                    tready = active;
                    if (active) begin
                        valid_nxt = 1'b1;
                        if (s_tvalid)
                            rgb_nxt = s_tdata;
                        else
                            underflow_set = 1'b1;
                    end
                    sof_miss = s_tvalid && !s_tuser && (h_cnt == '0) && (v_cnt == '0);
                end
                resync_nxt = resync || sof_miss;
                if (frame_end) begin
                    if (!en)
                        state_nxt = IDLE;
                    else if (resync_nxt)
                        state_nxt = WAIT_SOF;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (pat) begin
            valid_nxt = active;
            rgb_nxt   = active ? bar_rgb : '0;
        end

        if (state_nxt != RUN) resync_nxt = 1'b0;
    end

    assign s_tready = tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            h_cnt  <= '0;
            v_cnt  <= '0;
            resync <= 1'b0;
        end else begin
            state  <= state_nxt;
            h_cnt  <= h_nxt;
            v_cnt  <= v_nxt;
            resync <= resync_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_o <= ~SYNC_POL;
            vsync_o <= ~SYNC_POL;
            valid_o <= 1'b0;
            rgb_o   <= '0;
        end else begin
            hsync_o <= hsync_nxt;
            vsync_o <= vsync_nxt;
            valid_o <= valid_nxt;
            rgb_o   <= rgb_nxt;
        end
    end

    // Sticky flags: a new event in the same cycle wins over the clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            if (underflow_set)
                underflow <= 1'b1;
            else if (err_clr)
                underflow <= 1'b0;
            if (sof_miss)
                sync_err <= 1'b1;
            else if (err_clr)
                sync_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a tiny 8x6 raster (4x3 visible, active-low syncs).
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        err_clr;
    logic        pattern_sel = 1'b0;
    logic [23:0] s_tdata;
    logic        s_tvalid;
    logic        s_tuser;
    logic        s_tready;
    logic        hsync_o;
    logic        vsync_o;
    logic        valid_o;
    logic [23:0] rgb_o;
    logic        underflow;
    logic        sync_err;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .err_clr(err_clr),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .s_tdata(s_tdata),
        .s_tvalid(s_tvalid),
        .s_tuser(s_tuser),
        .s_tready(s_tready),
        .hsync_o(hsync_o),
        .vsync_o(vsync_o),
        .valid_o(valid_o),
        .rgb_o(rgb_o),
        .underflow(underflow),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        v;
        logic        u;
        logic [23:0] d;
    } beat_t;

    beat_t       src_q[$];
    logic [23:0] exp_q[$];
    int          pop_cyc[$];
    int          pops = 0;
    logic        meas = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_pops(input int n, input int budget);
        int k;
        k = 0;
        while (pops < n && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        check("wait_pixels", pops, n);
    endtask

    task automatic count_window(input int len, output int hl, output int vl);
        hl = 0;
        vl = 0;
        repeat (len) begin
            @(negedge clk);
            #2;
            if (!hsync_o) hl++;
            if (!vsync_o) vl++;
        end
    endtask

    // Upstream source: a beat with v=0 is a one-cycle bubble consumed unconditionally.
    initial begin
        logic fire;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tdata  = '0;
        forever begin
            @(negedge clk);
            if (src_q.size() > 0) begin
                s_tvalid = src_q[0].v;
                s_tuser  = src_q[0].u;
                s_tdata  = src_q[0].d;
            end else begin
                s_tvalid = 1'b0;
                s_tuser  = 1'b0;
                s_tdata  = '0;
            end
            #1;
            fire = (src_q.size() > 0) && !rst && (!src_q[0].v || s_tready);
            @(posedge clk);
            if (fire && !rst) void'(src_q.pop_front());
        end
    end

    // Pixel monitor: every displayed pixel pops one expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (valid_o === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL pixel_unexpected: got rgb %0h, expected no displayed pixel", rgb_o);
                    end else begin
                        check($sformatf("pixel_%0d", pops), {8'h00, rgb_o}, {8'h00, exp_q.pop_front()});
                    end
                    pop_cyc.push_back(cyc);
                    pops++;
                end else begin
                    check("blank_rgb", {8'h00, rgb_o}, 32'h0);
                end
            end
        end
    end

    // Sync shape monitor, active only while the raster runs continuously.
    initial begin
        logic ph;
        logic pv;
        int   hfall;
        int   vfall;
        ph = 1'b1;
        pv = 1'b1;
        hfall = -1;
        vfall = -1;
        forever begin
            @(negedge clk);
            if (meas) begin
                if (ph && !hsync_o) begin
                    if (hfall >= 0) check("hsync_period", cyc - hfall, 8);
                    hfall = cyc;
                end
                if (!ph && hsync_o && hfall >= 0) check("hsync_width", cyc - hfall, 2);
                if (pv && !vsync_o) begin
                    if (vfall >= 0) check("vsync_period", cyc - vfall, 48);
                    vfall = cyc;
                end
                if (!pv && vsync_o && vfall >= 0) check("vsync_width", cyc - vfall, 8);
            end else begin
                hfall = -1;
                vfall = -1;
            end
            ph = hsync_o;
            pv = vsync_o;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int hl;
        int vl;
        int k;
        rst     = 1'b1;
        en      = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);

        // Five stale beats, then frames of pixel n = n.
        for (int i = 0; i < 5; i++) src_q.push_back('{1'b1, 1'b0, 24'hA00000 + 24'(i)});
        for (int n = 0; n < 12; n++) begin
            src_q.push_back('{1'b1, n == 0, 24'(n)});
            exp_q.push_back(24'(n));
        end
        for (int n = 12; n < 23; n++) begin
            src_q.push_back('{1'b1, n == 12, 24'(n)});
            exp_q.push_back(24'(n));
            if (n == 16) begin
                src_q.push_back('{1'b0, 1'b0, 24'h0});
                exp_q.push_back(24'h0);
            end
        end
        for (int n = 23; n < 35; n++) begin
            src_q.push_back('{1'b1, 1'b0, 24'(n)});
            exp_q.push_back(24'(n));
        end
        for (int n = 35; n < 47; n++) begin
            src_q.push_back('{1'b1, n == 35, 24'(n)});
            exp_q.push_back(24'(n));
        end

        rst = 1'b0;
        repeat (50) begin
            @(negedge clk);
            #2;
            check("idle_syncs", {30'h0, hsync_o, vsync_o}, 32'h3);
            check("idle_tready", {31'h0, s_tready}, 32'h0);
        end
        check("rst_valid", {31'h0, valid_o}, 32'h0);
        check("rst_rgb", {8'h00, rgb_o}, 32'h0);
        check("rst_underflow", {31'h0, underflow}, 32'h0);
        check("rst_sync_err", {31'h0, sync_err}, 32'h0);

        en = 1'b1;
        c0 = cyc;
        wait_pops(1, 200);
        if (pop_cyc.size() > 0) check("first_pixel_latency", pop_cyc[0] - c0, 50);
        meas = 1'b1;

        wait_pops(12, 200);
        check("f1_underflow", {31'h0, underflow}, 32'h0);
        check("f1_sync_err", {31'h0, sync_err}, 32'h0);

        wait_pops(24, 200);
        check("f2_underflow_set", {31'h0, underflow}, 32'h1);
        check("f2_sync_err", {31'h0, sync_err}, 32'h0);
        err_clr = 1'b1;
        @(negedge clk);
        #2;
        err_clr = 1'b0;
        check("underflow_cleared", {31'h0, underflow}, 32'h0);

        wait_pops(36, 200);
        check("f3_sync_err_set", {31'h0, sync_err}, 32'h1);
        check("f3_underflow", {31'h0, underflow}, 32'h0);
        if (pop_cyc.size() >= 13) begin
            check("gap_in_line", pop_cyc[1] - pop_cyc[0], 1);
            check("gap_line_wrap", pop_cyc[4] - pop_cyc[3], 5);
            check("gap_frame_wrap", pop_cyc[12] - pop_cyc[11], 29);
        end
        count_window(48, hl, vl);
        check("hsync_low_per_frame", hl, 12);
        check("vsync_low_per_frame", vl, 8);

        wait_pops(40, 200);
        if (pop_cyc.size() >= 37) check("gap_resync_frame", pop_cyc[36] - pop_cyc[35], 77);
        en = 1'b0;
        count_window(60, hl, vl);
        check("vsync_low_after_en_drop", vl, 8);
        check("pixel_count", pops, 48);
        check("exp_queue_empty", exp_q.size(), 0);
        count_window(20, hl, vl);
        check("idle_hsync_low", hl, 0);
        check("idle_vsync_low", vl, 0);
        meas = 1'b0;

        for (int i = 0; i < 12; i++) src_q.push_back('{1'b1, 1'b0, 24'h550000 + 24'(i)});
        repeat (2) @(negedge clk);
        #2;
        check("idle_tready_with_data", {31'h0, s_tready}, 32'h0);
        check("idle_sync_err_sticky", {31'h0, sync_err}, 32'h1);

        en = 1'b1;
        k = 0;
        @(negedge clk);
        while (hsync_o !== 1'b0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("pre_rst_hsync", {31'h0, hsync_o}, 32'h0);
        check("pre_rst_tready", {31'h0, s_tready}, 32'h1);
        rst = 1'b1;
        #1;
        check("async_rst_hsync", {31'h0, hsync_o}, 32'h1);
        check("async_rst_vsync", {31'h0, vsync_o}, 32'h1);
        check("async_rst_valid", {31'h0, valid_o}, 32'h0);
        check("async_rst_rgb", {8'h00, rgb_o}, 32'h0);
        check("async_rst_tready", {31'h0, s_tready}, 32'h0);
        check("async_rst_sync_err", {31'h0, sync_err}, 32'h0);
        check("async_rst_underflow", {31'h0, underflow}, 32'h0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
